fw_sched: RTL and testbench

- Blocked Floyd-Warshall round scheduler that sequences the fw compute kernel.
- For each round k, it issues tile requests to the tile fetcher in dependency order: phase 0 (diagonal), then phase 1 (row/column), then phase 2 (remainder).
- It gates source beats into the kernel and drives the kernel's enable/inhibit/phase.
- It drains the kernel pipeline at every phase boundary so later phases see completed results.

---
 rtl/fw_sched_if.sv | 39 +++
 rtl/fw_sched.sv | 236 +++++++++++++++++++++++
 tb/tb_fw_sched.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fw_sched_if.sv
// fw_sched handshake bundle: start/config, tile fetcher, source beats,
// kernel controls and the optional perf counters.
interface fw_sched_if #(
  parameter int NBW = 8
) ();
  logic           start;
  logic [NBW-1:0] cfg_nb;
  logic           busy;
  logic           done;
  logic           tile_req;
  logic [NBW-1:0] tile_i;
  logic [NBW-1:0] tile_j;
  logic [NBW-1:0] tile_k;
  logic           tile_ack;
  logic           src_valid;
  logic           src_ready;
  logic           fw_enable;
  logic           fw_inhibit;
  logic [1:0]     fw_phase;
  logic           fw_in_valid;
  logic           fw_out_valid;
  logic           err;
  logic [31:0]    perf_drain;
  logic [31:0]    perf_stall;

  modport master (
    output start, cfg_nb, tile_ack, src_valid, fw_out_valid,
    input  busy, done, tile_req, tile_i, tile_j, tile_k,
    input  src_ready, fw_enable, fw_inhibit, fw_phase,
    input  fw_in_valid, err, perf_drain, perf_stall
  );

  modport slave (
    input  start, cfg_nb, tile_ack, src_valid, fw_out_valid,
    output busy, done, tile_req, tile_i, tile_j, tile_k,
    output src_ready, fw_enable, fw_inhibit, fw_phase,
    output fw_in_valid, err, perf_drain, perf_stall
  );
endinterface

// File: rtl/fw_sched.sv
// Blocked Floyd-Warshall round scheduler driving tile fetch and the fw kernel.
// Optional DRAIN/stall perf counters enabled by FW_SCHED_PERF_EN.
module fw_sched #(
  parameter int NBW        = 8,
  parameter int TILE_BEATS = 16,
  parameter int OCW        = 6
) (
  input logic       clk_i,
  input logic       rst_i,
  fw_sched_if.slave sched_io
);
  localparam int BW = (TILE_BEATS > 1) ? $clog2(TILE_BEATS) : 1;
  localparam logic [BW-1:0] LAST = BW'(TILE_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_STREAM, S_DRAIN, S_FIN
  } state_e;

  state_e         state_q, state_d;
  logic [NBW-1:0] nb_q, nb_d;
  logic [NBW-1:0] k_q, k_d;
  logic [NBW-1:0] i_q, i_d;
  logic [NBW-1:0] j_q, j_d;
  logic [1:0]     ph_q, ph_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [OCW-1:0] out_q, out_d;
  logic           err_q, err_d;

  logic           in_v;
  logic           has_nxt;
  logic [NBW-1:0] nx_i, nx_j;
  logic [NBW-1:0] first;
  logic [NBW:0]   k_w, nb_w, ni_w, nj_w, kn_w;

  // Next index on the non-k axis: step by one, hopping over k.
  function automatic logic [NBW:0] skip_k(
    input logic [NBW:0] x,
    input logic [NBW:0] k
  );
    logic [NBW:0] y;
    y = x + 1'b1;
    if (y == k) y = y + 1'b1;
    return y;
  endfunction

  assign k_w   = {1'b0, k_q};
  assign nb_w  = {1'b0, nb_q};
  assign kn_w  = k_w + 1'b1;
  assign first = (k_q == '0) ? NBW'(1) : '0;
  assign ni_w  = skip_k({1'b0, i_q}, k_w);
  assign nj_w  = skip_k({1'b0, j_q}, k_w);

  always_comb begin
    has_nxt = 1'b0;
    nx_i    = i_q;
    nx_j    = j_q;
    case (ph_q)
      2'd1: begin
        if (i_q == k_q) begin
          has_nxt = 1'b1;
          if (nj_w < nb_w) begin
            nx_j = nj_w[NBW-1:0];
          end else begin
            nx_i = first;
            nx_j = k_q;
          end
        end else if (ni_w < nb_w) begin
          has_nxt = 1'b1;
          nx_i    = ni_w[NBW-1:0];
        end
      end
      2'd2: begin
        if (nj_w < nb_w) begin
          has_nxt = 1'b1;
          nx_j    = nj_w[NBW-1:0];
        end else if (ni_w < nb_w) begin
          has_nxt = 1'b1;
          nx_i    = ni_w[NBW-1:0];
          nx_j    = first;
        end
      end
      default: ;
    endcase
  end

  assign in_v = sched_io.src_valid && (state_q == S_STREAM);

  always_comb begin
    out_d = out_q;
    err_d = err_q;
    case ({in_v, sched_io.fw_out_valid})
      2'b10: out_d = out_q + 1'b1;
      2'b01: begin
        if (out_q == '0) err_d = 1'b1;
        else out_d = out_q - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    ph_d    = ph_q;
    beat_d  = beat_q;
    case (state_q)
      S_IDLE: begin
        if (sched_io.start) begin
          if (sched_io.cfg_nb == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
            nb_d    = sched_io.cfg_nb;
            k_d     = '0;
            i_d     = '0;
            j_d     = '0;
            ph_d    = 2'd0;
          end
        end
      end
      S_ISSUE: begin
        if (sched_io.tile_ack) begin
          state_d = S_STREAM;
          beat_d  = '0;
        end
      end
      S_STREAM: begin
        if (sched_io.src_valid) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST) begin
            if (has_nxt) begin
              state_d = S_ISSUE;
              i_d     = nx_i;
              j_d     = nx_j;
            end else begin
              state_d = S_DRAIN;
            end
          end
        end
      end
      S_DRAIN: begin
        // Leave as the last result retires; empty phases fall through.
        if (out_d == '0) begin
          state_d = S_ISSUE;
          if (ph_q == 2'd0 && nb_q > NBW'(1)) begin
            ph_d = 2'd1;
            i_d  = k_q;
            j_d  = first;
          end else if (ph_q == 2'd1) begin
            ph_d = 2'd2;
            i_d  = first;
            j_d  = first;
          end else if (kn_w < nb_w) begin
            ph_d = 2'd0;
            k_d  = kn_w[NBW-1:0];
            i_d  = kn_w[NBW-1:0];
            j_d  = kn_w[NBW-1:0];
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      nb_q    <= '0;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      ph_q    <= 2'd0;
      beat_q  <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nb_q    <= nb_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ph_q    <= ph_d;
      beat_q  <= beat_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign sched_io.busy        = (state_q == S_ISSUE) ||
                                (state_q == S_STREAM) ||
                                (state_q == S_DRAIN);
  assign sched_io.done        = (state_q == S_FIN);
  assign sched_io.tile_req    = (state_q == S_ISSUE);
  assign sched_io.tile_i      = i_q;
  assign sched_io.tile_j      = j_q;
  assign sched_io.tile_k      = k_q;
  assign sched_io.src_ready   = (state_q == S_STREAM);
  assign sched_io.fw_enable   = (state_q == S_STREAM) ||
                                (state_q == S_DRAIN);
  assign sched_io.fw_inhibit  = (state_q != S_STREAM);
  assign sched_io.fw_phase    = ph_q;
  assign sched_io.fw_in_valid = in_v;
  assign sched_io.err         = err_q;

`ifdef FW_SCHED_PERF_EN
  logic [31:0] drain_q, stall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drain_q <= '0;
      stall_q <= '0;
    end else if (state_q == S_IDLE && sched_io.start) begin
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      if (state_q == S_DRAIN && drain_q != '1)
        drain_q <= drain_q + 1'b1;
      if (state_q == S_STREAM && !sched_io.src_valid &&
          stall_q != '1)
        stall_q <= stall_q + 1'b1;
    end
  end

  assign sched_io.perf_drain = drain_q;
  assign sched_io.perf_stall = stall_q;
`else
  assign sched_io.perf_drain = '0;
  assign sched_io.perf_stall = '0;
`endif
endmodule

// File: tb/tb_fw_sched.sv
// Bench for fw_sched: table of run scenarios against an 8-stage kernel
// model, tile-order scoreboard, plus error-flag and mid-stream reset cases.
module tb_fw_sched;
  localparam int LIMIT = 3000;

  typedef struct {
    logic [7:0] nb;
    int         ack_dly;
    bit         gap;
    bit         busy_start;
    int         exp_tiles;
    int         exp_drain;
  } vec_t;

  typedef struct packed {
    logic [7:0] k;
    logic [7:0] i;
    logic [7:0] j;
    logic [1:0] ph;
  } tile_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       inj;
  logic [7:0] kp;
  int         total = 0;
  int         bad = 0;
  tile_t      exp_q[$];
  vec_t       vecs[6];

  fw_sched_if #(.NBW(8)) bus ();

  fw_sched #(
    .NBW(8),
    .TILE_BEATS(16),
    .OCW(6)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sched_io(bus)
  );

  always #5 clk = ~clk;

  // Kernel model: fixed 8-cycle latency from in_valid to out_valid.
  always @(posedge clk or posedge rst) begin
    if (rst) kp <= '0;
    else kp <= {kp[6:0], bus.fw_in_valid};
  end
  assign bus.fw_out_valid = kp[7] | inj;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_req"}, bus.tile_req, 0);
    chk({tag, "_ti"}, bus.tile_i, 0);
    chk({tag, "_tj"}, bus.tile_j, 0);
    chk({tag, "_tk"}, bus.tile_k, 0);
    chk({tag, "_rdy"}, bus.src_ready, 0);
    chk({tag, "_en"}, bus.fw_enable, 0);
    chk({tag, "_inh"}, bus.fw_inhibit, 1);
    chk({tag, "_ph"}, bus.fw_phase, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  function automatic void push_t(int k, int i, int j, int p);
    tile_t t;
    t.k  = 8'(k);
    t.i  = 8'(i);
    t.j  = 8'(j);
    t.ph = 2'(p);
    exp_q.push_back(t);
  endfunction

  function automatic void build(int nb);
    for (int k = 0; k < nb; k++) begin
      push_t(k, k, k, 0);
      for (int j = 0; j < nb; j++)
        if (j != k) push_t(k, k, j, 1);
      for (int i = 0; i < nb; i++)
        if (i != k) push_t(k, i, k, 1);
      for (int i = 0; i < nb; i++)
        for (int j = 0; j < nb; j++)
          if (i != k && j != k) push_t(k, i, j, 2);
    end
  endfunction

  task automatic run(input vec_t v);
    int waitc, acks, beats, btile, dones, drains;
    int stalls, reqs, bout, tdone;
    logic [7:0] hk, hi, hj;
    logic [1:0] hp, pph;
    tile_t e;
    waitc = 0; acks = 0; beats = 0; btile = 0; dones = 0;
    drains = 0; stalls = 0; reqs = 0; bout = 0; tdone = -1;
    hk = '0; hi = '0; hj = '0; hp = '0;
    exp_q.delete();
    build(int'(v.nb));
    pph = bus.fw_phase;
    for (int cyc = 0; cyc < LIMIT; cyc++) begin
      @(posedge clk);
      #1;
      bus.start = (cyc == 0) || (v.busy_start && cyc == 30);
      bus.cfg_nb = (cyc == 0) ? v.nb : 8'd3;
      bus.src_valid = v.gap ? (cyc % 2 == 0) : 1'b1;
      bus.tile_ack = 1'b0;
      if (bus.tile_req) begin
        if (waitc == 0) begin
          hk = bus.tile_k; hi = bus.tile_i;
          hj = bus.tile_j; hp = bus.fw_phase;
        end else begin
          chk("hold_k", bus.tile_k, hk);
          chk("hold_i", bus.tile_i, hi);
          chk("hold_j", bus.tile_j, hj);
          chk("hold_ph", bus.fw_phase, hp);
        end
        bus.tile_ack = (waitc >= v.ack_dly);
        waitc++;
      end
      @(negedge clk);
      if (v.busy_start && cyc == 30)
        chk("busy_at_restart", bus.busy, 1);
      if (bus.fw_phase != pph)
        chk("phase_chg_outstanding", bout, 0);
      pph = bus.fw_phase;
      if (bus.tile_req) reqs++;
      if (bus.tile_req && bus.tile_ack) begin
        waitc = 0;
        if (acks > 0) chk("beats_per_tile", btile, 16);
        btile = 0;
        acks++;
        if (exp_q.size() == 0) begin
          chk("tile_count_over", acks, v.exp_tiles);
        end else begin
          e = exp_q.pop_front();
          chk("tile_k", bus.tile_k, e.k);
          chk("tile_i", bus.tile_i, e.i);
          chk("tile_j", bus.tile_j, e.j);
          chk("tile_ph", bus.fw_phase, e.ph);
        end
      end
      if (bus.fw_in_valid) begin
        beats++; btile++; bout++;
      end
      if (bus.fw_out_valid) bout--;
      if (bus.src_ready && !bus.src_valid) stalls++;
      if (bus.fw_enable && bus.fw_inhibit) drains++;
      if (bus.done) begin
        dones++;
        if (tdone < 0) tdone = cyc;
      end
      if (tdone >= 0 && cyc >= tdone + 3) break;
    end
    bus.start = 1'b0;
    bus.tile_ack = 1'b0;
    bus.src_valid = 1'b0;
    chk("done_count", dones, 1);
    chk("tile_count", acks, v.exp_tiles);
    chk("beat_total", beats, 16 * v.exp_tiles);
    chk("beats_last_tile", btile, (v.exp_tiles > 0) ? 16 : 0);
    chk("tiles_left", exp_q.size(), 0);
    chk("drain_cycles", drains, v.exp_drain);
    chk("run_err", bus.err, 0);
    chk("busy_after", bus.busy, 0);
    if (v.nb == 0) begin
      chk("nb0_reqs", reqs, 0);
      chk("nb0_done_latency_ok", (tdone >= 0 && tdone <= 2), 1);
    end
`ifdef FW_SCHED_PERF_EN
    chk("perf_drain", bus.perf_drain, v.exp_drain);
    chk("perf_stall", bus.perf_stall, stalls);
`endif
  endtask

  initial begin
    int seen;
    vecs[0] = '{8'd1, 0, 1'b0, 1'b0, 1, 8};
    vecs[1] = '{8'd2, 0, 1'b0, 1'b0, 8, 48};
    vecs[2] = '{8'd2, 5, 1'b1, 1'b0, 8, 48};
    vecs[3] = '{8'd2, 0, 1'b0, 1'b1, 8, 48};
    vecs[4] = '{8'd3, 1, 1'b0, 1'b0, 27, 72};
    vecs[5] = '{8'd0, 0, 1'b0, 1'b0, 0, 0};

    rst = 1'b0;
    inj = 1'b0;
    bus.start = 1'b0;
    bus.cfg_nb = '0;
    bus.tile_ack = 1'b0;
    bus.src_valid = 1'b0;
    #1 rst = 1'b1;
    #3 chk_reset("por");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    @(posedge clk);
    #1 inj = 1'b1;
    @(posedge clk);
    #1 inj = 1'b0;
    @(negedge clk);
    chk("err_set", bus.err, 1);
    chk("err_no_busy", bus.busy, 0);
    repeat (4) @(posedge clk);
    #1 chk("err_sticky", bus.err, 1);

    bus.cfg_nb = 8'd2;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.tile_ack = 1'b1;
    bus.src_valid = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (bus.src_ready) begin
        seen++;
        if (seen == 4) break;
      end
    end
    chk("stream_reached", seen, 4);
    #2 rst = 1'b1;
    #1 chk_reset("mid_stream");
    chk("mid_stream_inv", bus.fw_in_valid, 0);
    bus.tile_ack = 1'b0;
    bus.src_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    for (int n = 0; n < 6; n++) run(vecs[n]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
